// File: rtl/maj_vote_pipe_if.sv
// Handshake/bus bundle for maj_vote_pipe: input channel words and the voted output word.
// out_par exists only when MAJ_VOTE_PIPE_PARITY_EN is defined.
interface maj_vote_pipe_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NCH   = 3
);
    logic                   in_valid;
    logic                   in_ready;
    logic [NCH*WIDTH-1:0]   in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    logic                   out_unanimous;
`ifdef MAJ_VOTE_PIPE_PARITY_EN
    logic                   out_par;
`endif

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_unanimous
`ifdef MAJ_VOTE_PIPE_PARITY_EN
        , input out_par
`endif
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_unanimous
`ifdef MAJ_VOTE_PIPE_PARITY_EN
        , output out_par
`endif
    );
endinterface

// File: rtl/maj_vote_pipe.sv
// Two-stage pipelined NCH-channel bitwise majority voter with valid/ready flow control,
// unanimity flag and saturating disagreement counter. Optional out_par via MAJ_VOTE_PIPE_PARITY_EN.
module maj_vote_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NCH   = 3,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    maj_vote_pipe_if.slave    bus,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  err_cnt
);
    localparam int unsigned DW = NCH * WIDTH;
    localparam int unsigned VW = 3;
    localparam logic [VW-1:0]    HALF    = VW'(NCH / 2);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    if (NCH < 3 || NCH > 7 || (NCH % 2) == 0) begin : g_bad_nch
        $error("maj_vote_pipe: NCH must be odd and in 3..7");
    end
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("maj_vote_pipe: WIDTH must be in 1..64");
    end
    if (CNT_W < 2 || CNT_W > 32) begin : g_bad_cnt_w
        $error("maj_vote_pipe: CNT_W must be in 2..32");
    end

    logic             s1_valid_q, s1_valid_d;
    logic [DW-1:0]    s1_data_q,  s1_data_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_unan_q, out_unan_d;
    logic [CNT_W-1:0] err_cnt_q,  err_cnt_d;
`ifdef MAJ_VOTE_PIPE_PARITY_EN
    logic             out_par_q,  out_par_d;
`endif

    logic             s2_adv;
    logic             s1_adv;
    logic [WIDTH-1:0] maj;
    logic             unan;
    logic [VW-1:0]    ones;

    // Vote on the word held in S1.
    always_comb begin
        maj  = '0;
        unan = 1'b1;
        ones = '0;
        for (int unsigned b = 0; b < WIDTH; b++) begin
            ones = '0;
            for (int unsigned c = 0; c < NCH; c++) begin
                ones = ones + VW'(s1_data_q[c*WIDTH + b]);
            end
            maj[b] = (ones > HALF);
        end
        for (int unsigned c = 1; c < NCH; c++) begin
            if (s1_data_q[c*WIDTH +: WIDTH] != s1_data_q[WIDTH-1:0]) begin
                unan = 1'b0;
            end
        end
    end

    // Flow control and next-state for both stages and the counter.
    always_comb begin
        s2_adv     = !s2_valid_q || bus.out_ready;
        s1_adv     = !s1_valid_q || s2_adv;
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s2_valid_d = s2_valid_q;
        out_data_d = out_data_q;
        out_unan_d = out_unan_q;
        err_cnt_d  = err_cnt_q;
`ifdef MAJ_VOTE_PIPE_PARITY_EN
        out_par_d  = out_par_q;
`endif
        if (s1_adv) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_data_d = bus.in_data;
            end
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = maj;
                out_unan_d = unan;
`ifdef MAJ_VOTE_PIPE_PARITY_EN
                out_par_d  = ^maj;
`endif
            end
        end
        // Clear takes priority over a same-cycle increment.
        if (clr_cnt) begin
            err_cnt_d = '0;
        end else if (s2_valid_q && bus.out_ready && !out_unan_q && err_cnt_q != CNT_MAX) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            out_data_q <= '0;
            out_unan_q <= 1'b0;
            err_cnt_q  <= '0;
`ifdef MAJ_VOTE_PIPE_PARITY_EN
            out_par_q  <= 1'b0;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s2_valid_q <= s2_valid_d;
            out_data_q <= out_data_d;
            out_unan_q <= out_unan_d;
            err_cnt_q  <= err_cnt_d;
`ifdef MAJ_VOTE_PIPE_PARITY_EN
            out_par_q  <= out_par_d;
`endif
        end
    end

    assign bus.in_ready      = s1_adv;
    assign bus.out_valid     = s2_valid_q;
    assign bus.out_data      = out_data_q;
    assign bus.out_unanimous = out_unan_q;
`ifdef MAJ_VOTE_PIPE_PARITY_EN
    assign bus.out_par       = out_par_q;
`endif
    assign err_cnt           = err_cnt_q;

endmodule
